// File: rtl/dsi_sched_if.sv
// ---------------------------------------------------------------------------
// dsi_sched_if
// Groups the request/grant, latched-packet and lane-control signals of the
// DSI packet scheduler.
//   master : the packet builders / lane distributor environment
//            (drives requests, packet data, lane_done, err_clr).
//   slave  : the scheduler itself (drives grants, latched packet fields,
//            packet_done, ppi_lane_en, sched_busy, timeout_err).
// Handshake: a requester raises *_req with its data and holds both stable
// until the matching one-cycle *_gnt pulse. On the lane side, packet_done is
// a one-cycle start pulse and lane_done is a one-cycle finish pulse, honoured
// only while the scheduler is waiting for it.
// ---------------------------------------------------------------------------
interface dsi_sched_if;
   logic [1:0]  lane_cfg;
   logic        cmd_req;
   logic [63:0] cmd_packet;
   logic        cmd_gnt;
   logic        vid_req;
   logic [31:0] vid_header;
   logic [15:0] vid_wc;
   logic        vid_gnt;
   logic        sched_is_long;
   logic [63:0] sched_short;
   logic [31:0] sched_header;
   logic [15:0] sched_wc;
   logic        packet_done;
   logic        lane_done;
   logic [3:0]  ppi_lane_en;
   logic        sched_busy;
   logic        timeout_err;
   logic        err_clr;

   modport master (
      output lane_cfg, cmd_req, cmd_packet, vid_req, vid_header, vid_wc,
             lane_done, err_clr,
      input  cmd_gnt, vid_gnt, sched_is_long, sched_short, sched_header,
             sched_wc, packet_done, ppi_lane_en, sched_busy, timeout_err
   );

   modport slave (
      input  lane_cfg, cmd_req, cmd_packet, vid_req, vid_header, vid_wc,
             lane_done, err_clr,
      output cmd_gnt, vid_gnt, sched_is_long, sched_short, sched_header,
             sched_wc, packet_done, ppi_lane_en, sched_busy, timeout_err
   );
endinterface

// File: rtl/dsi_packet_scheduler.sv
// ---------------------------------------------------------------------------
// dsi_packet_scheduler
// Arbitrates between a command (short packet) and a video (long packet)
// requester, latches the winner, enables the PPI lanes for the configured
// lane count, pulses packet_done to start the distributor and holds the
// lanes until lane_done or a timeout.
// Ports:
//   i_dsi_clk   : sole clock, posedge.
//   i_dsi_rst   : asynchronous active-high reset.
//   bus         : dsi_sched_if.slave (requests, grants, latched packet,
//                 lane control, error flag).
//   o_dbg_state : current FSM state encoding (IDLE=0 .. RELEASE=4).
// ---------------------------------------------------------------------------
module dsi_packet_scheduler #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int STARVE_LIMIT   = 4,
   parameter int LANE_SETTLE    = 2
) (
   input  logic        i_dsi_clk,
   input  logic        i_dsi_rst,
   dsi_sched_if.slave  bus,
   output logic [2:0]  o_dbg_state
);

   localparam int TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t              r_state,    w_next_state;
   logic                r_cmd_gnt,  w_cmd_gnt;
   logic                r_vid_gnt,  w_vid_gnt;
   logic                r_pkt_done, w_pkt_done;
   logic                r_is_long,  w_is_long;
   logic [63:0]         r_short,    w_short;
   logic [31:0]         r_header,   w_header;
   logic [15:0]         r_wc,       w_wc;
   logic [3:0]          r_lane_en,  w_lane_en;
   logic [3:0]          r_settle,   w_settle;
   logic [TCNT_W-1:0]   r_tcnt,     w_tcnt;
   logic [STARVE_W-1:0] r_starve,   w_starve;
   logic                r_err,      w_err;
   logic                w_set_err;
   logic                w_vid_wins;

   function automatic logic [3:0] lane_mask(input logic [1:0] cfg);
      case (cfg)
         2'b01:   lane_mask = 4'b0001;
         2'b00:   lane_mask = 4'b0011;
         2'b10:   lane_mask = 4'b0111;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   // Video wins unless it is absent or the command has been starved long enough.
   assign w_vid_wins = bus.vid_req &&
                       !(bus.cmd_req && (r_starve == STARVE_W'(STARVE_LIMIT)));

   always_comb begin
      w_next_state = r_state;
      w_cmd_gnt    = 1'b0;
      w_vid_gnt    = 1'b0;
      w_pkt_done   = 1'b0;
      w_is_long    = r_is_long;
      w_short      = r_short;
      w_header     = r_header;
      w_wc         = r_wc;
      w_lane_en    = r_lane_en;
      w_settle     = r_settle;
      w_tcnt       = r_tcnt;
      w_starve     = r_starve;
      w_set_err    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.cmd_req || bus.vid_req) begin
               // The lane mask is frozen here; later lane_cfg changes wait
               // for the next grant.
               w_lane_en    = lane_mask(bus.lane_cfg);
               w_settle     = '0;
               w_next_state = S_SETTLE;
               if (w_vid_wins) begin
                  w_vid_gnt = 1'b1;
                  w_is_long = 1'b1;
                  w_header  = bus.vid_header;
                  w_wc      = bus.vid_wc;
                  if (!bus.cmd_req)
                     w_starve = '0;
                  else if (r_starve != STARVE_W'(STARVE_LIMIT))
                     w_starve = r_starve + 1'b1;
               end else begin
                  w_cmd_gnt = 1'b1;
                  w_is_long = 1'b0;
                  w_short   = bus.cmd_packet;
                  w_starve  = '0;
               end
            end
         end
         S_SETTLE: begin
            if (r_settle == 4'(LANE_SETTLE - 1))
               w_next_state = S_START;
            else
               w_settle = r_settle + 1'b1;
         end
         S_START: begin
            w_pkt_done   = 1'b1;
            w_tcnt       = '0;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            // lane_done takes priority over a timeout on the same cycle.
            if (bus.lane_done) begin
               w_lane_en    = 4'b0000;
               w_next_state = S_RELEASE;
            end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_set_err    = 1'b1;
               w_lane_en    = 4'b0000;
               w_next_state = S_RELEASE;
            end else begin
               w_tcnt = r_tcnt + 1'b1;
            end
         end
         S_RELEASE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_lane_en    = 4'b0000;
            w_next_state = S_IDLE;
         end
      endcase

      // A timeout set in the same cycle as err_clr leaves the flag set.
      if (w_set_err)
         w_err = 1'b1;
      else if (bus.err_clr)
         w_err = 1'b0;
      else
         w_err = r_err;
   end

   always_ff @(posedge i_dsi_clk or posedge i_dsi_rst) begin
      if (i_dsi_rst) begin
         r_state    <= S_IDLE;
         r_cmd_gnt  <= 1'b0;
         r_vid_gnt  <= 1'b0;
         r_pkt_done <= 1'b0;
         r_is_long  <= 1'b0;
         r_short    <= '0;
         r_header   <= '0;
         r_wc       <= '0;
         r_lane_en  <= '0;
         r_settle   <= '0;
         r_tcnt     <= '0;
         r_starve   <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_cmd_gnt  <= w_cmd_gnt;
         r_vid_gnt  <= w_vid_gnt;
         r_pkt_done <= w_pkt_done;
         r_is_long  <= w_is_long;
         r_short    <= w_short;
         r_header   <= w_header;
         r_wc       <= w_wc;
         r_lane_en  <= w_lane_en;
         r_settle   <= w_settle;
         r_tcnt     <= w_tcnt;
         r_starve   <= w_starve;
         r_err      <= w_err;
      end
   end

   assign bus.cmd_gnt       = r_cmd_gnt;
   assign bus.vid_gnt       = r_vid_gnt;
   assign bus.packet_done   = r_pkt_done;
   assign bus.sched_is_long = r_is_long;
   assign bus.sched_short   = r_short;
   assign bus.sched_header  = r_header;
   assign bus.sched_wc      = r_wc;
   assign bus.ppi_lane_en   = r_lane_en;
   assign bus.sched_busy    = (r_state != S_IDLE);
   assign bus.timeout_err   = r_err;
   assign o_dbg_state       = r_state;

endmodule
